ddr_req_queue: RTL and testbench
================================

Name: ddr_req_queue

Overview:
- Host-side request queue directly upstream of the DDR controller top.
- Buffers host read/write requests (address plus write data) in a FIFO.
- Presents one command at a time to the controller, gated by the controller's act_idle ("ready for next command") indication.
- Decouples bursty test-bench/host traffic from the controller's ACT/CAS/burst sequencing.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- ADDR_W, 32: request address width; matches the controller mem_addr width.
- DATA_W, 64: write data word carried with each request.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width; derived, not to be overridden.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- host_valid  in  1  host request present.
- host_ready  out  1  queue can accept; equals (count < DEPTH), combinational from registered count.
- host_rw  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  request address.
- host_data  in  DATA_W  write data; don't-care for reads, stored anyway.
- act_idle  in  1  controller idle and able to take a new command.
- cmd_valid  out  1  one-cycle command strobe to the controller.
- cmd_rw  out  1  registered rw of the issued command.
- cmd_addr  out  ADDR_W  registered address of the issued command.
- cmd_data  out  DATA_W  registered write data of the issued command.
- count  out  CNT_W  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (reset_n low at a clock edge) clears all of the following:
  - rd_ptr, wr_ptr, count.
  - cmd_valid, cmd_rw, cmd_addr, cmd_data all 0.
  - State goes to IDLE; empty=1, full=0, host_ready=1.
  - Reset mid-operation discards all queued entries and any in-flight strobe; the FIFO RAM contents need not be cleared.
- Push: host_valid && host_ready at an edge writes {rw, addr, data} at wr_ptr. wr_ptr wraps modulo DEPTH.
- Pop: occurs only on an issue (below). rd_ptr wraps modulo DEPTH.
- Count update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
  - When full, host_ready=0, so a push is impossible even if a pop happens in the same cycle. There is no pass-through of the freed slot.
- FSM states: IDLE, PRESENT, WAIT.
  - IDLE: count==0. Go to PRESENT when count becomes nonzero. First entry written at edge N gives PRESENT at N+1.
  - PRESENT, act_idle==1 at an edge:
    - Issue: register head entry onto cmd_*, cmd_valid=1 for exactly one cycle, pop.
    - Go to WAIT.
    - Minimum push-to-cmd_valid latency: 2 cycles.
  - PRESENT, act_idle==0: hold; cmd_valid=0.
  - WAIT: controller accepted and must drop act_idle.
    - Stay while act_idle==1.
    - On act_idle==0, go to PRESENT if count>0, else IDLE.
    - Guarantees no back-to-back issue before the controller has visibly gone busy.
- cmd_rw/addr/data hold their last issued value until the next issue. They are meaningful only when qualified by cmd_valid.
- A push in the same cycle as the pop of the last entry leaves count=1; the FSM goes from WAIT to PRESENT per the rules above.
- No overflow or underflow is possible by construction. A simulation assertion flags a push while full or a pop while empty.

Optional Feature:
- Macro DDR_REQ_QUEUE_STATS_EN.
- When defined, adds output ports:
  - hwm (CNT_W): occupancy high-water mark; updates when count > hwm.
  - wait_cycles (16 bits): counts cycles spent in PRESENT with act_idle==0; saturates at 16'hFFFF.
  - Both clear on reset.
- When undefined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle → empty=1, full=0, host_ready=1, count=0, cmd_valid=0 for 10 cycles.
- act_idle held 1; push write addr 32'h0000_1000 data 64'hA5A5 at cycle N → cmd_valid=1 at N+2 with cmd_rw=1, cmd_addr=32'h1000, cmd_data=64'hA5A5; count back to 0.
- act_idle=0; push 8 requests (DEPTH=8) → full=1, host_ready=0, count=8. A 9th host_valid is not accepted; no cmd_valid.
- Then toggle act_idle 1/0 per command → 8 strobes in FIFO order, addresses 0..7 in order; empty=1 after the last.
- act_idle stuck at 1 after an issue with 3 entries queued → exactly one cmd_valid, FSM held in WAIT. Dropping act_idle for 1 cycle then raising it → next strobe.
- With 4 entries queued, assert reset_n=0 for one edge → count=0, empty=1, cmd_valid=0, no further strobes. A subsequent push issues the new entry, not the stale ones.

Source files
------------

// File: rtl/ddr_req_queue.sv
// Host request FIFO feeding the DDR controller one command at a time, gated by act_idle.
// Optional occupancy/stall statistics (hwm, wait_cycles) under DDR_REQ_QUEUE_STATS_EN.
module ddr_req_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              act_idle,
  output logic              cmd_valid,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
`ifdef DDR_REQ_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hwm,
  output logic [15:0]       wait_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPresent, StWait} state_e;
  state_e state_q, state_d;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic              cmd_valid_q, cmd_rw_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_data_q;

  logic push, pop;

  assign host_ready = (count_q < DepthCnt);
  assign push       = host_valid && host_ready;
  assign pop        = (state_q == StPresent) && act_idle;

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == DepthCnt);
  assign cmd_valid  = cmd_valid_q;
  assign cmd_rw     = cmd_rw_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // WAIT holds until the controller visibly goes busy, preventing back-to-back issue.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (count_q != '0) state_d = StPresent;
      StPresent: if (act_idle) state_d = StWait;
      StWait:    if (!act_idle) state_d = (count_q != '0) ? StPresent : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cmd_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        cmd_rw_q   <= mem_rw_q[rd_ptr_q];
        cmd_addr_q <= mem_addr_q[rd_ptr_q];
        cmd_data_q <= mem_data_q[rd_ptr_q];
      end
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_rw_q[wr_ptr_q]   <= host_rw;
      mem_addr_q[wr_ptr_q] <= host_addr;
      mem_data_q[wr_ptr_q] <= host_data;
    end
  end

`ifdef DDR_REQ_QUEUE_STATS_EN
  logic [CNT_W-1:0] hwm_q;
  logic [15:0]      wait_cycles_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hwm_q         <= '0;
      wait_cycles_q <= '0;
    end else begin
      if (count_q > hwm_q) hwm_q <= count_q;
      if ((state_q == StPresent) && !act_idle && (wait_cycles_q != 16'hFFFF)) begin
        wait_cycles_q <= wait_cycles_q + 16'd1;
      end
    end
  end

  assign hwm         = hwm_q;
  assign wait_cycles = wait_cycles_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge clock) disable iff (!reset_n)
                                   !(push && (count_q == DepthCnt)));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
                                   !(pop && (count_q == '0)));
`endif

endmodule

// File: tb/tb_ddr_req_queue.sv
// Scoreboard bench for ddr_req_queue: accepted host requests are queued as expected commands,
// a negedge monitor pops them on each cmd_valid and checks occupancy and issue protocol.
module tb_ddr_req_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              host_valid;
  logic              host_ready;
  logic              host_rw;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              act_idle;
  logic              cmd_valid;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
`ifdef DDR_REQ_QUEUE_STATS_EN
  logic [CNT_W-1:0]  hwm;
  logic [15:0]       wait_cycles;
`endif

  ddr_req_queue #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_rw    (host_rw),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .act_idle   (act_idle),
    .cmd_valid  (cmd_valid),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .count      (count),
    .empty      (empty),
    .full       (full)
`ifdef DDR_REQ_QUEUE_STATS_EN
    ,
    .hwm        (hwm),
    .wait_cycles(wait_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } entry_t;

  entry_t exp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor state: inputs seen just before the coming edge, applied after it.
  int     cyc       = 0;
  logic   pend_rst  = 1'b1;
  logic   pend_push = 1'b0;
  logic   pend_act  = 1'b0;
  logic   need_busy = 1'b0;
  entry_t pend_e;
  int     strobes   = 0;
  int     last_lat  = -1;

  always @(negedge clock) begin
    entry_t e;
    cyc++;
    if (pend_rst) begin
      exp_q.delete();
      need_busy = 1'b0;
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_rw", 64'(cmd_rw), 64'd0);
      check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
      check("rst_cmd_data", cmd_data, 64'd0);
    end else begin
      if (cmd_valid) begin
        strobes++;
        check("strobe_act_idle", 64'(pend_act), 64'd1);
        check("strobe_after_busy", 64'(need_busy), 64'd0);
        need_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_rw", 64'(cmd_rw), 64'(e.rw));
          check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
          check("cmd_data", cmd_data, e.data);
          last_lat = cyc - e.cyc;
          check("latency_min", 64'(last_lat >= 2), 64'd1);
        end
      end
      if (pend_push) begin
        pend_e.cyc = cyc;
        exp_q.push_back(pend_e);
      end
    end
    check("count", 64'(count), 64'(exp_q.size()));
    check("empty", 64'(empty), 64'(exp_q.size() == 0));
    check("full", 64'(full), 64'(exp_q.size() == DEPTH));
    check("host_ready", 64'(host_ready), 64'(exp_q.size() < DEPTH));
    pend_rst    = !reset_n;
    pend_push   = host_valid && host_ready;
    pend_act    = act_idle;
    pend_e.rw   = host_rw;
    pend_e.addr = host_addr;
    pend_e.data = host_data;
    if (!act_idle) need_busy = 1'b0;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name, input int limit);
    int guard = 0;
    host_valid = 1'b0;
    act_idle   = 1'b1;
    while ((count != 0) && (guard < limit)) begin
      tick();
      act_idle = ~act_idle;
      guard++;
    end
    check(name, 64'(guard < limit), 64'd1);
    act_idle = 1'b0;
    tick();
    tick();
  endtask

  int s0;

  initial begin
    reset_n    = 1'b0;
    host_valid = 1'b0;
    host_rw    = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    act_idle   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();

    // Single write with controller ready: strobe two edges after the push.
    act_idle   = 1'b1;
    host_valid = 1'b1;
    host_rw    = 1'b1;
    host_addr  = 32'h0000_1000;
    host_data  = 64'hA5A5;
    s0 = strobes;
    tick();
    host_valid = 1'b0;
    repeat (4) tick();
    check("single_strobes", 64'(strobes - s0), 64'd1);
    check("single_latency", 64'(last_lat), 64'd2);
    check("single_empty", 64'(empty), 64'd1);

    // Fill while controller busy; ninth request rejected.
    act_idle = 1'b0;
    tick();
    s0 = strobes;
    for (int i = 0; i < 9; i++) begin
      host_valid = 1'b1;
      host_rw    = i[0];
      host_addr  = 32'(i);
      host_data  = 64'hD000_0000 + 64'(i);
      tick();
    end
    host_valid = 1'b0;
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(host_ready), 64'd0);
    check("fill_count", 64'(count), 64'd8);
    tick();
    check("fill_no_strobe", 64'(strobes - s0), 64'd0);

    drain("fill_drain_timeout", 40);
    check("fill_drain_strobes", 64'(strobes - s0), 64'd8);
    check("fill_drain_empty", 64'(empty), 64'd1);

    // act_idle stuck high after an issue: only one strobe until it drops.
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_rw    = 1'b0;
      host_addr  = 32'h300 + 32'(i);
      host_data  = 64'(i);
      tick();
    end
    host_valid = 1'b0;
    tick();
    s0 = strobes;
    act_idle = 1'b1;
    repeat (6) tick();
    check("stuck_one_strobe", 64'(strobes - s0), 64'd1);
    act_idle = 1'b0;
    tick();
    act_idle = 1'b1;
    tick();
    tick();
    check("stuck_next_strobe", 64'(strobes - s0), 64'd2);
    act_idle = 1'b0;
    tick();

    // Reset with four entries queued discards them.
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1;
      host_addr  = 32'h400 + 32'(i);
      tick();
    end
    host_valid = 1'b0;
    check("pre_reset_count", 64'(count), 64'd4);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("post_reset_count", 64'(count), 64'd0);
    check("post_reset_empty", 64'(empty), 64'd1);
    check("post_reset_valid", 64'(cmd_valid), 64'd0);
    s0 = strobes;
    act_idle = 1'b1;
    repeat (5) tick();
    check("post_reset_no_strobe", 64'(strobes - s0), 64'd0);
    host_valid = 1'b1;
    host_rw    = 1'b0;
    host_addr  = 32'h0000_BEEF;
    host_data  = 64'h1234;
    tick();
    host_valid = 1'b0;
    repeat (4) tick();
    check("post_reset_strobe", 64'(strobes - s0), 64'd1);
    check("post_reset_latency", 64'(last_lat), 64'd2);
    act_idle = 1'b0;
    tick();

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      host_valid = ($urandom_range(0, 99) < 60);
      host_rw    = 1'($urandom_range(0, 1));
      host_addr  = $urandom;
      host_data  = {$urandom, $urandom};
      act_idle   = 1'($urandom_range(0, 1));
      tick();
    end
    drain("rand_drain_timeout", 100);
    @(negedge clock);
    #1;
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
